dibu_code_loader: RTL and testbench
===================================

Name: dibu_code_loader

Overview:
- Serial boot loader for the dibu core.
- Receives a program over a UART line (8N1) and writes it into the datapath's code memory through its write port (code_w_en, code_addr_in, code_in).
- Holds the core stopped (run low) until the whole image has been written, then releases it.
- Sits beside the datapath at top level, clocked by the same divided clock; drives the datapath's run and code-write inputs in place of constants.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4.
- ADDR_W, 8, code memory address width; must be >= 8 so any 255-word image fits.
- CODE_W, 16, instruction width; fixed at 16 (two bytes per word).

Ports:
- clk  input  1  core clock (same domain as datapath).
- rst  input  1  synchronous, active-high reset.
- rx  input  1  UART serial input; idles high; asynchronous to clk.
- run  output  1  high once the load has completed; drives datapath run.
- code_w_en  output  1  one-cycle write strobe to code memory.
- code_addr_in  output  ADDR_W  code memory write address.
- code_in  output  CODE_W  code memory write data.
- busy  output  1  high from the first count byte received until DONE or ERR.
- error  output  1  sticky; high in ERR state.

Behaviour:
- Reset: run=0, code_w_en=0, code_addr_in=0, code_in=0, busy=0, error=0; FSM goes to S_COUNT; UART receiver returns to idle; word index clears to 0.
  - Reset applies at any point, including mid-byte or mid-image.
  - Words already written to code memory are not erased.
- rx synchroniser: rx passes through 2 flip-flops before use; the synchroniser flops reset to 1.
- UART receiver:
  - A falling edge on the synchronised rx starts a frame.
  - Start bit is re-sampled at CLKS_PER_BIT/2; if rx is high there, the edge is treated as a glitch and the receiver returns to idle with no byte and no error.
  - 8 data bits follow, LSB first, each sampled CLKS_PER_BIT cycles after the previous sample.
  - The stop bit is sampled one bit period after data bit 7.
  - Stop bit = 1: the byte is valid and is presented to the FSM as a one-cycle byte_valid at the stop-bit sample cycle.
  - Stop bit = 0: framing error; the FSM goes to S_ERR.
- Loader FSM, stepped only on byte_valid:
  - S_COUNT: the byte is the word count N.
    - N=0: go to S_DONE directly (run=1 the next cycle, no writes).
    - Otherwise store N, set busy=1, go to S_HI.
  - S_HI: latch the byte as the high data byte; go to S_LO.
  - S_LO: in the cycle after byte_valid, code_w_en=1 for exactly one cycle with code_addr_in = word index and code_in = {hi, lo}. Then:
    - Increment the word index.
    - If index+1 == N, go to S_DONE (or S_CSUM with the optional feature); otherwise go to S_HI.
  - S_DONE: run=1 and busy=0, held until rst; all further bytes are ignored.
  - S_ERR: error=1, run=0, busy=0, held until rst; all further bytes are ignored.
- Output hold rules:
  - code_addr_in and code_in hold their last values between strobes.
  - code_w_en is never high in S_DONE or S_ERR, except the final strobe, which occurs on the cycle the FSM enters S_DONE/S_CSUM.
- Word index wraps at 2^ADDR_W; unreachable for N <= 255.
- Framing error while in S_DONE: ignored, run stays 1.
- Latency from stop-bit sample to the write strobe: exactly 1 cycle.

Optional Feature:
- Macro: DIBU_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) is kept of all data bytes (hi and lo, not N).
  - After the last word, the FSM enters S_CSUM and waits for one more byte.
  - Byte equal to the sum: go to S_DONE.
  - Byte not equal to the sum: go to S_ERR (run stays 0, error=1). Words already written are not erased.
  - N=0 also expects a checksum byte of 0x00.
- Undefined: no S_CSUM state and no adder; the FSM goes to S_DONE directly after the last word.

Test Plan:
- CLKS_PER_BIT=4; rst high 3 cycles, then low; send bytes 0x02, 0x12, 0x34, 0xAB, 0xCD.
  - Required: two strobes, addr 0 data 0x1234, then addr 1 data 0xABCD.
  - run rises the cycle after the 2nd strobe; busy falls at the same time; error=0.
- Send 0x00 → run=1 one cycle after that byte's stop sample; code_w_en never asserted.
- Send 0x01, then 0x55 with stop bit driven 0 → error=1, run=0, no strobe; a following valid image is ignored until rst.
- 1-cycle low glitch on rx while idle, then 0x01, 0x00, 0x07 → glitch rejected; one strobe, addr 0 data 0x0007; run=1.
- Send 0x03, 0x11, 0x22; assert rst for 1 cycle mid third byte; then send 0x01, 0xBE, 0xEF → after rst all outputs are 0; one strobe, addr 0 data 0xBEEF; run=1.
- With DIBU_LOADER_CHECKSUM_EN:
  - 0x01, 0x12, 0x34, 0x46 → run=1.
  - Repeat with last byte 0x47 → error=1, run=0; strobe addr 0 data 0x1234 still observed.

Source files
------------

// File: rtl/dibu_code_loader.sv
// Serial (UART 8N1) boot loader: writes a word-count-prefixed image into code memory, then releases run.
// Optional trailing checksum byte enabled by defining DIBU_LOADER_CHECKSUM_EN.
module dibu_code_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8,
  parameter int CODE_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              run,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [CODE_W-1:0] code_in,
  output logic              busy,
  output logic              error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

`ifdef DIBU_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_COUNT, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} ld_state_t;
`else
  typedef enum logic [2:0] {S_COUNT, S_HI, S_LO, S_DONE, S_ERR} ld_state_t;
`endif

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  uart_state_t       r_ustate;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;

  ld_state_t         r_state;
  logic [7:0]        r_count;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_idx;
  logic              r_run;
  logic              r_code_w_en;
  logic [ADDR_W-1:0] r_code_addr;
  logic [CODE_W-1:0] r_code;
  logic              r_busy;
  logic              r_error;
`ifdef DIBU_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic              w_stop_sample;
  logic              w_byte_valid;
  logic              w_frame_err;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_idx_next;
  logic              w_last_word;

  // Stop-bit sample cycle doubles as the byte strobe, so the write lands exactly one cycle later.
  assign w_stop_sample = (r_ustate == U_STOP) && (r_cnt == BIT_END);
  assign w_byte_valid  = w_stop_sample && r_rx_sync;
  assign w_frame_err   = w_stop_sample && !r_rx_sync;
  assign w_byte        = r_shift;
  assign w_idx_next    = r_idx + 1'b1;
  assign w_last_word   = (w_idx_next == ADDR_W'(r_count));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_ustate  <= U_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      case (r_ustate)
        U_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_ustate <= U_START;
            r_cnt    <= CNT_W'(1);
          end
        end
        U_START: begin
          if (r_cnt == HALF) begin
            // A start bit that is high again at mid-bit was only a glitch.
            r_ustate <= r_rx_sync ? U_IDLE : U_DATA;
            r_cnt    <= CNT_W'(1);
            r_bit    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_cnt == BIT_END) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_cnt   <= CNT_W'(1);
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_ustate <= U_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (r_cnt == BIT_END) r_ustate <= U_IDLE;
          else                  r_cnt    <= r_cnt + 1'b1;
        end
        default: r_ustate <= U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COUNT;
      r_count     <= '0;
      r_hi        <= '0;
      r_idx       <= '0;
      r_run       <= 1'b0;
      r_code_w_en <= 1'b0;
      r_code_addr <= '0;
      r_code      <= '0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
`ifdef DIBU_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_code_w_en <= 1'b0;
      if (w_frame_err && r_state != S_DONE && r_state != S_ERR) begin
        r_state <= S_ERR;
        r_error <= 1'b1;
        r_run   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_COUNT: begin
            if (w_byte_valid) begin
              if (w_byte == 8'd0) begin
`ifdef DIBU_LOADER_CHECKSUM_EN
                r_state <= S_CSUM;
                r_busy  <= 1'b1;
`else
                r_state <= S_DONE;
                r_run   <= 1'b1;
`endif
              end else begin
                r_count <= w_byte;
                r_busy  <= 1'b1;
                r_state <= S_HI;
              end
            end
          end
          S_HI: begin
            if (w_byte_valid) begin
              r_hi    <= w_byte;
`ifdef DIBU_LOADER_CHECKSUM_EN
              r_sum   <= r_sum + w_byte;
`endif
              r_state <= S_LO;
            end
          end
          S_LO: begin
            if (w_byte_valid) begin
              r_code_w_en <= 1'b1;
              r_code_addr <= r_idx;
              r_code      <= CODE_W'({r_hi, w_byte});
              r_idx       <= w_idx_next;
`ifdef DIBU_LOADER_CHECKSUM_EN
              r_sum       <= r_sum + w_byte;
              r_state     <= w_last_word ? S_CSUM : S_HI;
`else
              r_state     <= w_last_word ? S_DONE : S_HI;
`endif
            end
          end
`ifdef DIBU_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (w_byte_valid) begin
              if (w_byte == r_sum) begin
                r_state <= S_DONE;
                r_run   <= 1'b1;
              end else begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end
              r_busy <= 1'b0;
            end
          end
`endif
          S_DONE: begin
            r_run  <= 1'b1;
            r_busy <= 1'b0;
          end
          S_ERR: begin
            r_error <= 1'b1;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_ERR;
        endcase
      end
    end
  end

  assign run          = r_run;
  assign code_w_en    = r_code_w_en;
  assign code_addr_in = r_code_addr;
  assign code_in      = r_code;
  assign busy         = r_busy;
  assign error        = r_error;

endmodule

// File: tb/tb_dibu_code_loader.sv
// Directed bench for dibu_code_loader at CLKS_PER_BIT=4; one line per byte sent and per check failure.
module tb_dibu_code_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        run;
  logic        code_w_en;
  logic [7:0]  code_addr_in;
  logic [15:0] code_in;
  logic        busy;
  logic        error;

  dibu_code_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .CODE_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .run(run), .code_w_en(code_w_en),
    .code_addr_in(code_addr_in), .code_in(code_in), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and edge log, sampled mid-cycle.
  logic [7:0]  st_addr[$];
  logic [15:0] st_data[$];
  int          st_cyc[$];
  int          run_rise_cyc  = -1;
  int          busy_fall_cyc = -1;
  logic        prev_run  = 1'b0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    if (code_w_en) begin
      st_addr.push_back(code_addr_in);
      st_data.push_back(code_in);
      st_cyc.push_back(cyc);
    end
    if (run && !prev_run)   run_rise_cyc  = cyc;
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev_run  = run;
    prev_busy = busy;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic slot_val(input logic [7:0] b, input logic stop, input int s);
    if (s < CPB)       return 1'b0;
    if (s < 9 * CPB)   return b[(s - CPB) / CPB];
    if (s < 10 * CPB)  return stop;
    return 1'b1;
  endfunction

  // One frame plus two idle bit times; c = cycle label of the first start-bit slot.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int c);
    @(posedge clk); #1;
    c = cyc;
    for (int s = 0; s < 12 * CPB; s++) begin
      rx = slot_val(b, stop, s);
      @(posedge clk); #1;
    end
    $display("tx byte 0x%02h stop=%0d start_cyc=%0d", b, stop, c);
  endtask

  logic       snap_busy_before;
  logic [27:0] snap_after;

  task automatic send_byte_rst(input logic [7:0] b, input int rst_slot);
    @(posedge clk); #1;
    for (int s = 0; s <= rst_slot; s++) begin
      rx = slot_val(b, 1'b1, s);
      if (s == rst_slot) begin
        snap_busy_before = busy;
        rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    rx  = 1'b1;
    snap_after = {run, code_w_en, code_addr_in, code_in, busy, error};
    repeat (12 * CPB) @(posedge clk);
    #1;
    $display("tx partial byte 0x%02h with rst at slot %0d", b, rst_slot);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int c0, c1, c2, base;

  initial begin
    do_reset();
    check("rst_run",   {31'd0, run},       32'd0);
    check("rst_wen",   {31'd0, code_w_en}, 32'd0);
    check("rst_addr",  {24'd0, code_addr_in}, 32'd0);
    check("rst_data",  {16'd0, code_in},   32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_error", {31'd0, error},     32'd0);

`ifndef DIBU_LOADER_CHECKSUM_EN
    // Two-word image
    base = st_addr.size();
    send_byte(8'h02, 1'b1, c0);
    check("t1_busy_after_count", {31'd0, busy}, 32'd1);
    send_byte(8'h12, 1'b1, c0);
    send_byte(8'h34, 1'b1, c1);
    send_byte(8'hAB, 1'b1, c0);
    send_byte(8'hCD, 1'b1, c2);
    check("t1_nstrobe", st_addr.size() - base, 32'd2);
    check("t1_addr0", {24'd0, st_addr[base]},   32'h0);
    check("t1_data0", {16'd0, st_data[base]},   32'h1234);
    check("t1_cyc0",  st_cyc[base],             c1 + 10 * CPB + 1);
    check("t1_addr1", {24'd0, st_addr[base+1]}, 32'h1);
    check("t1_data1", {16'd0, st_data[base+1]}, 32'hABCD);
    check("t1_cyc1",  st_cyc[base+1],           c2 + 10 * CPB + 1);
    check("t1_run_rise",  run_rise_cyc,  c2 + 10 * CPB + 2);
    check("t1_busy_fall", busy_fall_cyc, c2 + 10 * CPB + 2);
    check("t1_run",   {31'd0, run},   32'd1);
    check("t1_error", {31'd0, error}, 32'd0);

    // Empty image
    do_reset();
    base = st_addr.size();
    send_byte(8'h00, 1'b1, c0);
    check("t2_run_rise", run_rise_cyc, c0 + 10 * CPB + 1);
    check("t2_nstrobe",  st_addr.size() - base, 32'd0);
    check("t2_run",      {31'd0, run},  32'd1);
    check("t2_busy",     {31'd0, busy}, 32'd0);

    // Framing error, then an ignored image
    do_reset();
    base = st_addr.size();
    send_byte(8'h01, 1'b1, c0);
    send_byte(8'h55, 1'b0, c0);
    check("t3_error",   {31'd0, error}, 32'd1);
    check("t3_run",     {31'd0, run},   32'd0);
    check("t3_busy",    {31'd0, busy},  32'd0);
    send_byte(8'h01, 1'b1, c0);
    send_byte(8'hAA, 1'b1, c0);
    send_byte(8'hBB, 1'b1, c0);
    check("t3_nstrobe",     st_addr.size() - base, 32'd0);
    check("t3_error_held",  {31'd0, error}, 32'd1);
    check("t3_run_held",    {31'd0, run},   32'd0);

    // Start-bit glitch rejection
    do_reset();
    base = st_addr.size();
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (6 * CPB) @(posedge clk);
    #1;
    $display("tx 1-cycle glitch");
    check("t4_glitch_busy",  {31'd0, busy},  32'd0);
    check("t4_glitch_error", {31'd0, error}, 32'd0);
    send_byte(8'h01, 1'b1, c0);
    send_byte(8'h00, 1'b1, c0);
    send_byte(8'h07, 1'b1, c0);
    check("t4_nstrobe", st_addr.size() - base, 32'd1);
    check("t4_addr0",   {24'd0, st_addr[base]}, 32'h0);
    check("t4_data0",   {16'd0, st_data[base]}, 32'h0007);
    check("t4_run",     {31'd0, run}, 32'd1);

    // Reset mid-image, then a fresh image
    do_reset();
    base = st_addr.size();
    send_byte(8'h03, 1'b1, c0);
    send_byte(8'h11, 1'b1, c0);
    send_byte_rst(8'h22, 5 * CPB);
    check("t5_busy_before", {31'd0, snap_busy_before}, 32'd1);
    check("t5_outs_after",  {4'd0, snap_after}, 32'd0);
    send_byte(8'h01, 1'b1, c0);
    send_byte(8'hBE, 1'b1, c0);
    send_byte(8'hEF, 1'b1, c0);
    check("t5_nstrobe", st_addr.size() - base, 32'd1);
    check("t5_addr0",   {24'd0, st_addr[base]}, 32'h0);
    check("t5_data0",   {16'd0, st_data[base]}, 32'hBEEF);
    check("t5_run",     {31'd0, run}, 32'd1);
`else
    // Checksum accepted
    base = st_addr.size();
    send_byte(8'h01, 1'b1, c0);
    send_byte(8'h12, 1'b1, c0);
    send_byte(8'h34, 1'b1, c0);
    check("c1_run_before_sum", {31'd0, run}, 32'd0);
    send_byte(8'h46, 1'b1, c0);
    check("c1_run",   {31'd0, run},   32'd1);
    check("c1_error", {31'd0, error}, 32'd0);
    check("c1_data0", {16'd0, st_data[base]}, 32'h1234);

    // Checksum rejected
    do_reset();
    base = st_addr.size();
    send_byte(8'h01, 1'b1, c0);
    send_byte(8'h12, 1'b1, c0);
    send_byte(8'h34, 1'b1, c0);
    send_byte(8'h47, 1'b1, c0);
    check("c2_error",   {31'd0, error}, 32'd1);
    check("c2_run",     {31'd0, run},   32'd0);
    check("c2_nstrobe", st_addr.size() - base, 32'd1);
    check("c2_addr0",   {24'd0, st_addr[base]}, 32'h0);
    check("c2_data0",   {16'd0, st_data[base]}, 32'h1234);

    // Empty image still needs a zero checksum
    do_reset();
    send_byte(8'h00, 1'b1, c0);
    check("c3_run_before_sum", {31'd0, run}, 32'd0);
    send_byte(8'h00, 1'b1, c0);
    check("c3_run", {31'd0, run}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
